// File: rtl/core_run_monitor.sv
// Run controller and halt monitor for the single-cycle RISC-V core.
// Generates the core reset pulse, gates execution and stops on the first halt cause.
//
// Ports:
//   clk, reset (async, active-low)    clock and reset
//   start, abort                      run control (start pulse, abort level)
//   pc, instr                         core PC and fetched instruction
//   mem_write, data_addr, write_data  core store traffic
//   bp_pc, bp_en                      PC breakpoint addresses and enables
//   core_reset, core_run              active-high core reset, core clock-enable
//   busy, done                        state in RESET/RUN, state is HALT
//   halt_cause, bp_idx                why the run stopped, breakpoint that fired
//   cycle_count, tohost_value         RUN cycles of this run, captured tohost data
module core_run_monitor #(
  parameter int              XLEN        = 32,
  parameter int              RST_CYCLES  = 2,
  parameter int              MAX_CYCLES  = 18,
  parameter int              NUM_BP      = 2,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 'h100,
  localparam int             BW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [XLEN-1:0]        pc,
  input  logic [XLEN-1:0]        instr,
  input  logic                   mem_write,
  input  logic [XLEN-1:0]        data_addr,
  input  logic [XLEN-1:0]        write_data,
  input  logic [NUM_BP*XLEN-1:0] bp_pc,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   core_reset,
  output logic                   core_run,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             halt_cause,
  output logic [BW-1:0]          bp_idx,
  output logic [31:0]            cycle_count,
  output logic [XLEN-1:0]        tohost_value
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESET = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_PASS  = 3'd1;
  localparam logic [2:0] C_FAIL  = 3'd2;
  localparam logic [2:0] C_BP    = 3'd3;
  localparam logic [2:0] C_TMO   = 3'd4;
  localparam logic [2:0] C_ILL   = 3'd5;
  localparam logic [2:0] C_ABORT = 3'd6;

  localparam int         RCW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam logic [RCW-1:0] RLOAD = RCW'(RST_CYCLES - 1);
  // Timeout compares the pre-increment count, so done shows MAX_CYCLES.
  localparam logic [31:0] LAST_CYC = 32'(MAX_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [RCW-1:0]  rcnt_q, rcnt_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [2:0]      cause_q, cause_d;
  logic [BW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] toh_q, toh_d;

  logic          bp_hit;
  logic [BW-1:0] bp_sel;
  logic          toh_hit;
  logic          ill_hit;
  logic          tmo_hit;

  // Scan downwards so the lowest matching index is the one left in bp_sel.
  always_comb begin
    bp_hit = 1'b0;
    bp_sel = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc == bp_pc[i*XLEN +: XLEN])) begin
        bp_hit = 1'b1;
        bp_sel = BW'(i);
      end
    end
  end

  assign toh_hit = mem_write && (data_addr == TOHOST_ADDR);
  assign ill_hit = (instr == '0) || (instr == '1);
  assign tmo_hit = (MAX_CYCLES != 0) && (cnt_q == LAST_CYC);

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    idx_d   = idx_q;
    toh_d   = toh_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_RESET;
          rcnt_d  = RLOAD;
          cnt_d   = '0;
          cause_d = C_NONE;
          idx_d   = '0;
          toh_d   = '0;
        end
      end
      S_RESET: begin
        if (abort) begin
          state_d = S_HALT;
          cause_d = C_ABORT;
        end else if (rcnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
        if (toh_hit) begin
          state_d = S_HALT;
          toh_d   = write_data;
          cause_d = (write_data == XLEN'(1)) ? C_PASS : C_FAIL;
        end else if (abort) begin
          state_d = S_HALT;
          cause_d = C_ABORT;
        end else if (ill_hit) begin
          state_d = S_HALT;
          cause_d = C_ILL;
        end else if (bp_hit) begin
          state_d = S_HALT;
          cause_d = C_BP;
          idx_d   = bp_sel;
        end else if (tmo_hit) begin
          state_d = S_HALT;
          cause_d = C_TMO;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      cnt_q   <= '0;
      cause_q <= C_NONE;
      idx_q   <= '0;
      toh_q   <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      idx_q   <= idx_d;
      toh_q   <= toh_d;
    end
  end

  assign core_reset   = (state_q == S_IDLE) || (state_q == S_RESET);
  assign core_run     = (state_q == S_RUN);
  assign busy         = (state_q == S_RESET) || (state_q == S_RUN);
  assign done         = (state_q == S_HALT);
  assign halt_cause   = cause_q;
  assign bp_idx       = idx_q;
  assign cycle_count  = cnt_q;
  assign tohost_value = toh_q;

endmodule

// File: tb/tb_core_run_monitor.sv
// Bench for core_run_monitor: table of halt scenarios plus hand sequences.
// Expected halt results are queued at start and compared when done rises.
module tb_core_run_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        mem_write;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic [63:0] bp_pc;
  logic [1:0]  bp_en;
  logic        core_reset;
  logic        core_run;
  logic        busy;
  logic        done;
  logic [2:0]  halt_cause;
  logic        bp_idx;
  logic [31:0] cycle_count;
  logic [31:0] tohost_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_run_monitor dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pc(pc), .instr(instr), .mem_write(mem_write),
    .data_addr(data_addr), .write_data(write_data),
    .bp_pc(bp_pc), .bp_en(bp_en),
    .core_reset(core_reset), .core_run(core_run),
    .busy(busy), .done(done), .halt_cause(halt_cause),
    .bp_idx(bp_idx), .cycle_count(cycle_count),
    .tohost_value(tohost_value)
  );

  typedef struct {
    int          ev;
    bit          st;
    logic [31:0] wd;
    int          il;
    bit          bp;
    logic [1:0]  en;
    bit          sp;
    logic [2:0]  cause;
    logic [31:0] cnt;
    logic [31:0] val;
    logic        idx;
  } vec_t;

  vec_t vecs[10];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; mem_write = 0;
    data_addr = 32'h200; write_data = 0;
    instr = 32'h13; pc = 32'h1000;
  endtask

  task automatic drive(input vec_t v, input int k);
    idle_inputs();
    pc = 32'h1000 + 32'(k * 4);
    bp_en = v.en;
    if (k == v.ev) begin
      if (v.st) begin
        mem_write = 1; data_addr = 32'h100; write_data = v.wd;
      end
      if (v.il == 1) instr = 32'h0;
      if (v.il == 2) instr = 32'hFFFF_FFFF;
      if (v.bp) pc = 32'h20;
      if (v.sp) start = 1;
    end
  endtask

  task automatic pop_cmp(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s_sb: got empty queue expected entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_run"}, 32'(core_run), 32'd0);
    chk({tag, "_creset"}, 32'(core_reset), 32'd0);
    chk({tag, "_cause"}, 32'(halt_cause), 32'(e.cause));
    chk({tag, "_cnt"}, cycle_count, e.cnt);
    chk({tag, "_val"}, tohost_value, e.val);
    chk({tag, "_idx"}, 32'(bp_idx), 32'(e.idx));
  endtask

  task automatic start_run(input string tag);
    int lat;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk({tag, "_clr_cause"}, 32'(halt_cause), 32'd0);
    chk({tag, "_clr_cnt"}, cycle_count, 32'd0);
    chk({tag, "_clr_val"}, tohost_value, 32'd0);
    chk({tag, "_rst_hi"}, 32'(core_reset), 32'd1);
    lat = 0;
    while (!core_run && lat < 10) begin
      @(negedge clk); lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int k;
    exp_q.push_back(v);
    start_run(tag);
    k = 0;
    while (!done && k < 40) begin
      drive(v, k);
      @(negedge clk);
      k++;
    end
    idle_inputs();
    if (!done) begin
      errors++; checks++;
      $display("FAIL %s_halt: got no done expected done", tag);
    end
    pop_cmp(tag);
  endtask

  initial begin
    vecs[0] = '{99, 0, 32'h0,    0, 0, 2'b00, 0, 3'd4, 32'd18, 32'h0,    1'b0};
    vecs[1] = '{5,  1, 32'h1,    0, 0, 2'b00, 0, 3'd1, 32'd6,  32'h1,    1'b0};
    vecs[2] = '{5,  1, 32'hDEAD, 0, 0, 2'b00, 0, 3'd2, 32'd6,  32'hDEAD, 1'b0};
    vecs[3] = '{3,  0, 32'h0,    0, 1, 2'b11, 0, 3'd3, 32'd4,  32'h0,    1'b0};
    vecs[4] = '{3,  0, 32'h0,    0, 1, 2'b10, 0, 3'd3, 32'd4,  32'h0,    1'b1};
    vecs[5] = '{3,  0, 32'h0,    0, 1, 2'b00, 0, 3'd4, 32'd18, 32'h0,    1'b0};
    vecs[6] = '{17, 1, 32'h1,    0, 1, 2'b11, 0, 3'd1, 32'd18, 32'h1,    1'b0};
    vecs[7] = '{4,  0, 32'h0,    1, 1, 2'b11, 0, 3'd5, 32'd5,  32'h0,    1'b0};
    vecs[8] = '{2,  0, 32'h0,    2, 0, 2'b00, 0, 3'd5, 32'd3,  32'h0,    1'b0};
    vecs[9] = '{3,  0, 32'h0,    0, 0, 2'b00, 1, 3'd4, 32'd18, 32'h0,    1'b0};

    bp_pc = {32'h20, 32'h20};
    bp_en = 2'b00;
    idle_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_core_run", 32'(core_run), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cause", 32'(halt_cause), 32'd0);
    chk("rst_cnt", cycle_count, 32'd0);
    reset = 1;

    abort = 1;
    repeat (3) @(negedge clk);
    abort = 0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_done", 32'(done), 32'd0);
    chk("idle_abort_creset", 32'(core_reset), 32'd1);

    for (int i = 0; i < 10; i++) begin
      bp_en = vecs[i].en;
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    abort = 1;
    repeat (3) @(negedge clk);
    abort = 0;
    chk("halt_abort_done", 32'(done), 32'd1);
    chk("halt_abort_cause", 32'(halt_cause), 32'd4);
    chk("halt_abort_cnt", cycle_count, 32'd18);

    bp_en = 2'b00;
    exp_q.push_back('{0, 0, 32'h0, 0, 0, 2'b00, 0, 3'd6, 32'd0, 32'h0, 1'b0});
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; abort = 1;
    @(negedge clk); abort = 0;
    pop_cmp("rst_abort");

    start_run("midrun");
    repeat (7) @(negedge clk);
    chk("midrun_cnt7", cycle_count, 32'd7);
    reset = 0;
    #1;
    chk("midrun_creset", 32'(core_reset), 32'd1);
    chk("midrun_run", 32'(core_run), 32'd0);
    chk("midrun_busy", 32'(busy), 32'd0);
    chk("midrun_done", 32'(done), 32'd0);
    chk("midrun_cnt", cycle_count, 32'd0);
    @(negedge clk);
    reset = 1;
    run_vec(vecs[0], "fresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/core_run_monitor.md
# core_run_monitor

Synthesizable run controller and halt monitor for the single-cycle RISC-V core. It generates the core's reset pulse and gates core execution. It watches PC, instruction and data-memory store traffic, and stops the run on the first halt condition: tohost store, PC breakpoint, illegal instruction, cycle limit or abort. It sits between the top-level bring-up logic or bench and `Single_Cycle_Top`, and replaces fixed-count stop logic with a parametrised, multi-cause halt mechanism that also works in hardware.

## Interface
- `XLEN`, 32, data/address width
- `RST_CYCLES`, 2, cycles core_reset is held high after start (≥1)
- `MAX_CYCLES`, 18, run-cycle limit; 0 = unlimited
- `NUM_BP`, 2, number of PC breakpoint comparators (≥1)
- `TOHOST_ADDR`, 32'h0000_0100, store address that ends the test
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low (0 = in reset)
- `start`  in  1  pulse; begins a run from IDLE or HALT
- `abort`  in  1  level; forces halt from RESET or RUN
- `pc`, `instr`  in  XLEN each  core PC and fetched instruction
- `mem_write`  in  1  core store strobe
- `data_addr`, `write_data`  in  XLEN each  store address/data
- `bp_pc`  in  NUM_BP*XLEN  breakpoint addresses, entry i at [i*XLEN +: XLEN]
- `bp_en`  in  NUM_BP  per-breakpoint enable
- `core_reset`  out  1  active-high reset to core
- `core_run`  out  1  core clock-enable
- `busy`, `done`  out  1 each  state in RESET/RUN; state == HALT
- `halt_cause`  out  3  0 none, 1 pass, 2 fail, 3 breakpoint, 4 timeout, 5 illegal, 6 abort
- `bp_idx`  out  max(1,$clog2(NUM_BP))  breakpoint that fired
- `cycle_count`  out  32  RUN cycles of the current run
- `tohost_value`  out  XLEN  data captured at the tohost store

## Operation
- FSM with states IDLE, RESET, RUN, HALT. Outputs are decoded from registered state or are registers; there is no combinational input-to-output path.
- IDLE: core_reset=1, core_run=0. On `start` → RESET; clear cycle_count, halt_cause, bp_idx, tohost_value.
- RESET: core_reset=1 for exactly RST_CYCLES cycles (down-counter), then → RUN. `abort` → HALT with cause 6.
- RUN: core_reset=0, core_run=1. Every edge samples the inputs and evaluates halt conditions in this priority order:
  1. Store with mem_write=1 and data_addr==TOHOST_ADDR: capture write_data. Cause 1 if value==1, otherwise cause 2.
  2. `abort`: cause 6.
  3. Illegal instruction, instr==0 or all-ones: cause 5.
  4. Breakpoint, pc==bp_pc[i] with bp_en[i]=1: cause 3. The lowest i wins and is reported on bp_idx.
  5. Timeout, MAX_CYCLES≠0 and cycle_count==MAX_CYCLES-1: cause 4.
- Any halt condition in RUN → HALT.
- HALT: core_reset=0, core_run=0, so the core state stays frozen for inspection. halt_cause, bp_idx, cycle_count and tohost_value hold their values. `start` → RESET (new run). `abort` is ignored.
- `start` is ignored in RESET and RUN. `abort` is ignored in IDLE.
- cycle_count increments on every RUN edge, including the halting edge. It saturates at 2^32-1.

## Timing
- Reset values: core_reset=1, core_run=0, busy=0, done=0, halt_cause=0, bp_idx=0, cycle_count=0, tohost_value=0, state IDLE.
- Assertion of `reset` at any time, including mid-run, returns immediately (asynchronously) to the reset values. The core is put back into reset.
- `start` sampled high at edge T: core_reset stays high for edges T+1..T+RST_CYCLES; core_run=1 from T+RST_CYCLES.
- Halt condition sampled at edge H: the core also commits on edge H, so the halting instruction or store completes. At H, core_run falls, done rises and halt_cause is valid; all three change together.
- Run cycles: with no other event, timeout gives cycle_count==MAX_CYCLES at done.
- Tohost priority: a tohost store coinciding with a breakpoint, timeout or illegal instruction reports pass or fail.
- Restart: `start` in HALT clears the result registers one cycle later, on entry to RESET.

## Test plan
- Timeout: defaults, start pulse, no events → core_reset high 2 cycles, done with halt_cause=4, cycle_count=18.
- Pass: store data_addr=0x100, write_data=1 at run cycle 5 → halt_cause=1, tohost_value=1, cycle_count=6. Repeat with write_data=0xDEAD → halt_cause=2, tohost_value=0xDEAD.
- Breakpoints: bp_pc={0x20,0x20}, bp_en=2'b11, pc reaches 0x20 → halt_cause=3, bp_idx=0. With bp_en=2'b10 → bp_idx=1. With bp_en=0 → no halt (timeout).
- Priority: same edge has tohost store (value 1), breakpoint hit and cycle_count==17 → halt_cause=1. Same edge has instr=0 and breakpoint → halt_cause=5.
- Abort: abort during RESET → halt_cause=6, cycle_count=0. Abort in IDLE → stays IDLE. Start during RUN → ignored.
- Reset mid-run: drive reset=0 at run cycle 7 → all outputs at reset values immediately. Next start → fresh run, cycle_count counts from 0.
